// File: rtl/goal_detector_if.sv
// Scoring handshake bundle between ball motion, goal detector and score.
// Latency: n/a (wires only).
// Backpressure: resetflag is the level acknowledge that releases a held collision flag.
//
// master : the goal detector (drives flags, hold, serve, serve_dir, ack_err)
// slave  : ball-motion / score environment (drives frame_tick, ball_x, resetflag)
interface goal_detector_if #(
    parameter int X_W = 10
);
    logic           frame_tick;
    logic [X_W-1:0] ball_x;
    logic           resetflag;
    logic           collision_flag1;
    logic           collision_flag2;
    logic           ball_hold;
    logic           serve;
    logic           serve_dir;
    logic           ack_err;

    modport master (
        input  frame_tick, ball_x, resetflag,
        output collision_flag1, collision_flag2, ball_hold, serve, serve_dir, ack_err
    );

    modport slave (
        output frame_tick, ball_x, resetflag,
        input  collision_flag1, collision_flag2, ball_hold, serve, serve_dir, ack_err
    );
endinterface

// File: rtl/goal_detector.sv
// Goal detector: flags a goal when the ball enters a goal zone, holds it until score acks, re-serves.
// Latency: flag/ball_hold one clk after the detecting frame_tick; serve one clk after terminal tick.
// Backpressure: a raised flag is held (and the ball frozen) until resetflag is sampled high.
//
// Ports: clk, reset (async active-low), gi (goal_detector_if.master):
//   in  frame_tick, ball_x, resetflag
//   out collision_flag1, collision_flag2, ball_hold, serve, serve_dir, ack_err
// Optional: define GOAL_ACK_TIMEOUT_EN to give up on a missing ack after ACK_TIMEOUT
// cycles and record it in sticky ack_err; otherwise ack_err is tied low.
module goal_detector #(
    parameter int X_W          = 10,
    parameter int GOAL_L       = 8,
    parameter int GOAL_R       = 631,
    parameter int SERVE_FRAMES = 60,
    parameter int ACK_TIMEOUT  = 1024
) (
    input  logic             clk,
    input  logic             reset,
    goal_detector_if.master  gi
);

    typedef enum logic [1:0] {
        PLAY       = 2'd0,
        GOAL       = 2'd1,
        SERVE_WAIT = 2'd2
    } state_t;

    localparam int CW = $clog2(SERVE_FRAMES) + 1;
    localparam logic [X_W-1:0] GOAL_L_X   = X_W'(GOAL_L);
    localparam logic [X_W-1:0] GOAL_R_X   = X_W'(GOAL_R);
    localparam logic [CW-1:0]  SERVE_LAST = CW'(SERVE_FRAMES - 1);

    state_t         state_q, state_n;
    logic [CW-1:0]  frame_cnt_q, frame_cnt_n;
    logic           flag1_q, flag1_n;
    logic           flag2_q, flag2_n;
    logic           hold_q, hold_n;
    logic           serve_q, serve_n;
    logic           dir_q, dir_n;

`ifdef GOAL_ACK_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

    logic [TW-1:0]  to_cnt_q, to_cnt_n;
    logic           ack_err_q, ack_err_n;
`endif

    always_comb begin
        state_n     = state_q;
        frame_cnt_n = frame_cnt_q;
        flag1_n     = flag1_q;
        flag2_n     = flag2_q;
        serve_n     = 1'b0;
        dir_n       = dir_q;
`ifdef GOAL_ACK_TIMEOUT_EN
        // Timeout counter only advances while waiting in GOAL; it restarts at 0 each goal.
        to_cnt_n    = '0;
        ack_err_n   = ack_err_q;
`endif

        case (state_q)
            PLAY: begin
                if (gi.frame_tick) begin
                    // Side 1 is checked first so a misconfigured overlap never raises both flags.
                    if (gi.ball_x <= GOAL_L_X) begin
                        state_n = GOAL;
                        flag1_n = 1'b1;
                        dir_n   = 1'b0;
                    end else if (gi.ball_x >= GOAL_R_X) begin
                        state_n = GOAL;
                        flag2_n = 1'b1;
                        dir_n   = 1'b1;
                    end
                end
            end

            GOAL: begin
                if (gi.resetflag) begin
                    state_n     = SERVE_WAIT;
                    flag1_n     = 1'b0;
                    flag2_n     = 1'b0;
                    frame_cnt_n = '0;
                end
`ifdef GOAL_ACK_TIMEOUT_EN
                // An ack arriving on the terminal cycle wins, so ack_err is left alone then.
                else if (to_cnt_q == TO_LAST) begin
                    state_n     = SERVE_WAIT;
                    flag1_n     = 1'b0;
                    flag2_n     = 1'b0;
                    frame_cnt_n = '0;
                    ack_err_n   = 1'b1;
                end else begin
                    to_cnt_n = to_cnt_q + 1'b1;
                end
`endif
            end

            SERVE_WAIT: begin
                if (gi.frame_tick) begin
                    if (frame_cnt_q == SERVE_LAST) begin
                        state_n     = PLAY;
                        serve_n     = 1'b1;
                        frame_cnt_n = '0;
                    end else begin
                        frame_cnt_n = frame_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_n     = SERVE_WAIT;
                frame_cnt_n = '0;
                flag1_n     = 1'b0;
                flag2_n     = 1'b0;
            end
        endcase

        // Registered hold tracks the next state so it drops on the same edge as serve.
        hold_n = (state_n != PLAY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SERVE_WAIT;
            frame_cnt_q <= '0;
            flag1_q     <= 1'b0;
            flag2_q     <= 1'b0;
            hold_q      <= 1'b1;
            serve_q     <= 1'b0;
            dir_q       <= 1'b0;
        end else begin
            state_q     <= state_n;
            frame_cnt_q <= frame_cnt_n;
            flag1_q     <= flag1_n;
            flag2_q     <= flag2_n;
            hold_q      <= hold_n;
            serve_q     <= serve_n;
            dir_q       <= dir_n;
        end
    end

`ifdef GOAL_ACK_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q  <= '0;
            ack_err_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_n;
            ack_err_q <= ack_err_n;
        end
    end

    assign gi.ack_err = ack_err_q;
`else
    assign gi.ack_err = 1'b0;
`endif

    assign gi.collision_flag1 = flag1_q;
    assign gi.collision_flag2 = flag2_q;
    assign gi.ball_hold       = hold_q;
    assign gi.serve           = serve_q;
    assign gi.serve_dir       = dir_q;

endmodule

// File: tb/tb_goal_detector.sv
// Directed bench for goal_detector with SERVE_FRAMES=3, ACK_TIMEOUT=16.
// Inputs are driven and outputs sampled 1 time unit after each rising clk edge.
// Build with or without GOAL_ACK_TIMEOUT_EN; the timeout scenario adapts.
module tb_goal_detector;

    logic clk;
    logic reset;
    int   vectors;
    int   errors;

    goal_detector_if #(.X_W(10)) gi ();

    goal_detector #(
        .X_W         (10),
        .GOAL_L      (8),
        .GOAL_R      (631),
        .SERVE_FRAMES(3),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .gi   (gi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // One-cycle frame_tick carrying position x; returns just after the sampling edge.
    task automatic send_tick(input logic [9:0] x);
        gi.frame_tick = 1'b1;
        gi.ball_x     = x;
        step();
        gi.frame_tick = 1'b0;
        gi.ball_x     = 10'd320;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        gi.frame_tick = 1'b0;
        gi.ball_x     = 10'd320;
        gi.resetflag  = 1'b0;
        #22;
        vectors++; if (gi.collision_flag1 !== 1'b0) begin errors++; $display("FAIL reset_flag1: got %b want 0", gi.collision_flag1); end
        vectors++; if (gi.collision_flag2 !== 1'b0) begin errors++; $display("FAIL reset_flag2: got %b want 0", gi.collision_flag2); end
        vectors++; if (gi.ball_hold !== 1'b1) begin errors++; $display("FAIL reset_hold: got %b want 1", gi.ball_hold); end
        vectors++; if (gi.serve !== 1'b0) begin errors++; $display("FAIL reset_serve: got %b want 0", gi.serve); end
        vectors++; if (gi.serve_dir !== 1'b0) begin errors++; $display("FAIL reset_dir: got %b want 0", gi.serve_dir); end
        vectors++; if (gi.ack_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err: got %b want 0", gi.ack_err); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_initial_serve();
        logic any_flag;
        any_flag = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            send_tick(10'd320);
            any_flag |= gi.collision_flag1 | gi.collision_flag2;
            if (t < 3) begin
                vectors++; if (gi.serve !== 1'b0 || gi.ball_hold !== 1'b1) begin errors++; $display("FAIL init_early_serve tick%0d: serve=%b hold=%b want serve=0 hold=1", t, gi.serve, gi.ball_hold); end
                for (int c = 0; c < 9; c++) begin
                    step();
                    any_flag |= gi.collision_flag1 | gi.collision_flag2 | gi.serve;
                end
            end
        end
        vectors++; if (gi.serve !== 1'b1) begin errors++; $display("FAIL init_serve: got %b want 1", gi.serve); end
        vectors++; if (gi.ball_hold !== 1'b0) begin errors++; $display("FAIL init_hold_fall: got %b want 0", gi.ball_hold); end
        vectors++; if (gi.serve_dir !== 1'b0) begin errors++; $display("FAIL init_dir: got %b want 0", gi.serve_dir); end
        step();
        vectors++; if (gi.serve !== 1'b0 || gi.ball_hold !== 1'b0) begin errors++; $display("FAIL init_serve_pulse: serve=%b hold=%b want 0 0", gi.serve, gi.ball_hold); end
        vectors++; if (any_flag !== 1'b0) begin errors++; $display("FAIL init_no_flags: got %b want 0", any_flag); end
    endtask

    task automatic test_goal_side2();
        // Goal position without frame_tick must be ignored.
        gi.ball_x = 10'd635;
        step();
        gi.ball_x = 10'd320;
        vectors++; if (gi.collision_flag2 !== 1'b0 || gi.ball_hold !== 1'b0) begin errors++; $display("FAIL s2_no_tick: flag2=%b hold=%b want 0 0", gi.collision_flag2, gi.ball_hold); end
        send_tick(10'd635);
        vectors++; if (gi.collision_flag2 !== 1'b1 || gi.collision_flag1 !== 1'b0) begin errors++; $display("FAIL s2_flags: f1=%b f2=%b want 0 1", gi.collision_flag1, gi.collision_flag2); end
        vectors++; if (gi.ball_hold !== 1'b1 || gi.serve_dir !== 1'b1) begin errors++; $display("FAIL s2_hold_dir: hold=%b dir=%b want 1 1", gi.ball_hold, gi.serve_dir); end
        idle(2);
        gi.resetflag = 1'b1;
        step();
        gi.resetflag = 1'b0;
        vectors++; if (gi.collision_flag2 !== 1'b0) begin errors++; $display("FAIL s2_ack: got %b want 0", gi.collision_flag2); end
        // Goal positions during SERVE_WAIT must not score again.
        for (int t = 1; t <= 3; t++) begin
            send_tick(10'd5);
            vectors++; if (gi.collision_flag1 !== 1'b0) begin errors++; $display("FAIL s2_wait_noscore tick%0d: got %b want 0", t, gi.collision_flag1); end
            if (t < 3) idle(9);
        end
        vectors++; if (gi.serve !== 1'b1 || gi.serve_dir !== 1'b1 || gi.ball_hold !== 1'b0) begin errors++; $display("FAIL s2_serve: serve=%b dir=%b hold=%b want 1 1 0", gi.serve, gi.serve_dir, gi.ball_hold); end
        step();
    endtask

    task automatic test_goal_side1();
        send_tick(10'd5);
        vectors++; if (gi.collision_flag1 !== 1'b1 || gi.collision_flag2 !== 1'b0) begin errors++; $display("FAIL s1_flags: f1=%b f2=%b want 1 0", gi.collision_flag1, gi.collision_flag2); end
        vectors++; if (gi.ball_hold !== 1'b1 || gi.serve_dir !== 1'b0) begin errors++; $display("FAIL s1_hold_dir: hold=%b dir=%b want 1 0", gi.ball_hold, gi.serve_dir); end
        // Opposite-goal ticks while in GOAL: no second flag.
        send_tick(10'd635);
        send_tick(10'd635);
        vectors++; if (gi.collision_flag2 !== 1'b0 || gi.collision_flag1 !== 1'b1) begin errors++; $display("FAIL s1_no_double: f1=%b f2=%b want 1 0", gi.collision_flag1, gi.collision_flag2); end
        step();
        gi.resetflag = 1'b1;
        step();
        gi.resetflag = 1'b0;
        vectors++; if (gi.collision_flag1 !== 1'b0 || gi.ball_hold !== 1'b1) begin errors++; $display("FAIL s1_ack: f1=%b hold=%b want 0 1", gi.collision_flag1, gi.ball_hold); end
        for (int t = 1; t <= 3; t++) begin
            send_tick(10'd320);
            if (t < 3) begin
                vectors++; if (gi.serve !== 1'b0) begin errors++; $display("FAIL s1_early_serve tick%0d: got %b want 0", t, gi.serve); end
                idle(9);
            end
        end
        vectors++; if (gi.serve !== 1'b1 || gi.serve_dir !== 1'b0) begin errors++; $display("FAIL s1_serve: serve=%b dir=%b want 1 0", gi.serve, gi.serve_dir); end
        step();
    endtask

    task automatic test_stuck_ack();
        gi.resetflag = 1'b1;
        send_tick(10'd5);
        vectors++; if (gi.collision_flag1 !== 1'b1) begin errors++; $display("FAIL stuck_flag_rise: got %b want 1", gi.collision_flag1); end
        step();
        vectors++; if (gi.collision_flag1 !== 1'b0 || gi.ball_hold !== 1'b1) begin errors++; $display("FAIL stuck_one_cycle: f1=%b hold=%b want 0 1", gi.collision_flag1, gi.ball_hold); end
        gi.resetflag = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            send_tick(10'd320);
            if (t < 3) idle(9);
        end
        vectors++; if (gi.serve !== 1'b1) begin errors++; $display("FAIL stuck_serve: got %b want 1", gi.serve); end
        step();
    endtask

    task automatic test_async_reset();
        send_tick(10'd635);
        vectors++; if (gi.collision_flag2 !== 1'b1) begin errors++; $display("FAIL ar_flag2_rise: got %b want 1", gi.collision_flag2); end
        #3 reset = 1'b0;
        #1;
        vectors++; if (gi.collision_flag2 !== 1'b0 || gi.ball_hold !== 1'b1) begin errors++; $display("FAIL ar_flag_drop: f2=%b hold=%b want 0 1", gi.collision_flag2, gi.ball_hold); end
        #2 reset = 1'b1;
        step();
        // Resumes in SERVE_WAIT: goal positions ignored, serve after 3 ticks with reset direction.
        for (int t = 1; t <= 3; t++) begin
            send_tick(10'd5);
            if (t < 3) begin
                vectors++; if (gi.collision_flag1 !== 1'b0 || gi.serve !== 1'b0) begin errors++; $display("FAIL ar_resume tick%0d: f1=%b serve=%b want 0 0", t, gi.collision_flag1, gi.serve); end
                idle(9);
            end
        end
        vectors++; if (gi.serve !== 1'b1 || gi.serve_dir !== 1'b0) begin errors++; $display("FAIL ar_serve: serve=%b dir=%b want 1 0", gi.serve, gi.serve_dir); end
        // Reset during the serve pulse drops it immediately.
        #3 reset = 1'b0;
        #1;
        vectors++; if (gi.serve !== 1'b0 || gi.ball_hold !== 1'b1) begin errors++; $display("FAIL ar_serve_drop: serve=%b hold=%b want 0 1", gi.serve, gi.ball_hold); end
        #2 reset = 1'b1;
        step();
        for (int t = 1; t <= 3; t++) begin
            send_tick(10'd320);
            if (t < 3) idle(9);
        end
        vectors++; if (gi.serve !== 1'b1) begin errors++; $display("FAIL ar_reserve: got %b want 1", gi.serve); end
        step();
    endtask

    task automatic test_ack_timeout();
        int hi_cycles;
        send_tick(10'd5);
        hi_cycles = 0;
`ifdef GOAL_ACK_TIMEOUT_EN
        for (int c = 0; c < 40 && gi.collision_flag1 === 1'b1; c++) begin
            hi_cycles++;
            step();
        end
        vectors++; if (hi_cycles != 16) begin errors++; $display("FAIL to_flag_cycles: got %0d want 16", hi_cycles); end
        vectors++; if (gi.ack_err !== 1'b1 || gi.ball_hold !== 1'b1) begin errors++; $display("FAIL to_ack_err: err=%b hold=%b want 1 1", gi.ack_err, gi.ball_hold); end
        for (int t = 1; t <= 3; t++) begin
            send_tick(10'd320);
            if (t < 3) idle(9);
        end
        vectors++; if (gi.serve !== 1'b1) begin errors++; $display("FAIL to_serve: got %b want 1", gi.serve); end
        step();
        send_tick(10'd635);
        vectors++; if (gi.collision_flag2 !== 1'b1 || gi.ack_err !== 1'b1) begin errors++; $display("FAIL to_sticky_goal: f2=%b err=%b want 1 1", gi.collision_flag2, gi.ack_err); end
        gi.resetflag = 1'b1;
        step();
        gi.resetflag = 1'b0;
        vectors++; if (gi.collision_flag2 !== 1'b0 || gi.ack_err !== 1'b1) begin errors++; $display("FAIL to_sticky_ack: f2=%b err=%b want 0 1", gi.collision_flag2, gi.ack_err); end
`else
        for (int c = 0; c < 120; c++) begin
            if (gi.collision_flag1 === 1'b1) hi_cycles++;
            step();
        end
        vectors++; if (hi_cycles != 120) begin errors++; $display("FAIL nto_flag_held: got %0d cycles want 120", hi_cycles); end
        vectors++; if (gi.collision_flag1 !== 1'b1 || gi.ack_err !== 1'b0) begin errors++; $display("FAIL nto_state: f1=%b err=%b want 1 0", gi.collision_flag1, gi.ack_err); end
        gi.resetflag = 1'b1;
        step();
        gi.resetflag = 1'b0;
        vectors++; if (gi.collision_flag1 !== 1'b0) begin errors++; $display("FAIL nto_ack: got %b want 0", gi.collision_flag1); end
`endif
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_initial_serve();
        test_goal_side2();
        test_goal_side1();
        test_stuck_ack();
        test_async_reset();
        test_ack_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
